// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the configurable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        MATCH = 2'd2
    } seq_state_t;

    localparam int DEF_LEN   = 5;
    localparam int DEF_CNT_W = 8;

    // Pattern bit LEN-1 is the first serial bit expected.
    localparam bit PAT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; a coincident clear and increment yields a count of one.
module seq_det_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_cfg.sv
// Serial pattern detector with loadable pattern and overlap control.
// Define SEQ_DET_CNT_EN to add the saturating match counter (cnt_clr / match_cnt).
module seq_detector_cfg
    import seq_det_pkg::*;
#(
    parameter int             LEN         = DEF_LEN,
    parameter int             CNT_W       = DEF_CNT_W,
    parameter logic [LEN-1:0] RST_PATTERN = {LEN{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    // Handshake: a bit is taken on every rising edge where in_valid is high and
    // pat_load is low; there is no backpressure, so the block is always ready.
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_data,
`ifdef SEQ_DET_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             out,
    output logic [1:0]       dbg_state
);

    localparam int             FW   = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(LEN);

    if (LEN < 2 || LEN > 32 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("seq_detector_cfg: LEN or CNT_W out of range");
    end

    seq_state_t     state;
    logic [LEN-1:0] pat;
    logic [LEN-1:0] hist;
    logic [LEN-1:0] hist_n;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_n;
    logic           accept;
    logic           match_evt;

    always_comb begin
        accept = in_valid & ~pat_load;
        if (PAT_MSB_FIRST) begin
            hist_n = {hist[LEN-2:0], in};
        end else begin
            hist_n = {in, hist[LEN-1:1]};
        end
        fill_n    = (fill == FULL) ? FULL : fill + FW'(1);
        match_evt = accept && (fill_n == FULL) && (hist_n == pat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat   <= RST_PATTERN;
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            out   <= 1'b0;
        end else if (pat_load) begin
            pat   <= pat_data;
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            out   <= 1'b0;
        end else if (match_evt) begin
            state <= MATCH;
            out   <= 1'b1;
            // Non-overlapping mode demands LEN fresh bits before the next match.
            if (overlap) begin
                hist <= hist_n;
                fill <= fill_n;
            end else begin
                hist <= '0;
                fill <= '0;
            end
        end else if (accept) begin
            hist  <= hist_n;
            fill  <= fill_n;
            state <= (fill_n == FULL) ? ARMED : FILL;
            out   <= 1'b0;
        end else begin
            out <= 1'b0;
            if (state == MATCH) begin
                state <= overlap ? ARMED : FILL;
            end
        end
    end

    assign dbg_state = state;

`ifdef SEQ_DET_CNT_EN
    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (match_evt),
        .cnt   (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detector_cfg.sv
// Bench for seq_detector_cfg (LEN=5, CNT_W=3, reset pattern 5'b11011); counter
// checks are active when SEQ_DET_CNT_EN is defined.
module tb_seq_detector_cfg;

    localparam int             LEN     = 5;
    localparam int             CNT_W   = 3;
    localparam logic [LEN-1:0] RST_PAT = 5'b11011;
    localparam int             CNT_MAX = 7;

    logic           clk;
    logic           reset;
    logic           in;
    logic           in_valid;
    logic           overlap;
    logic           pat_load;
    logic [LEN-1:0] pat_data;
    logic           cnt_clr;
    logic [CNT_W-1:0] match_cnt;
    logic           out;
    logic [1:0]     dbg_state;

    seq_detector_cfg #(
        .LEN         (LEN),
        .CNT_W       (CNT_W),
        .RST_PATTERN (RST_PAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_data  (pat_data),
`ifdef SEQ_DET_CNT_EN
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt),
`endif
        .out       (out),
        .dbg_state (dbg_state)
    );

`ifndef SEQ_DET_CNT_EN
    assign match_cnt = '0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: the last accepted bits since the last clear
    bit             mq[$];
    logic [LEN-1:0] mpat;
    int             mcnt;
    logic [3:0]     exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic i, input logic v,
                                input logic o, input logic l,
                                input logic [LEN-1:0] d, input logic c);
        bit             m;
        logic [LEN-1:0] val;
        m = 1'b0;
        if (r) begin
            mq.delete();
            mpat = RST_PAT;
            mcnt = 0;
        end else begin
            if (l) begin
                mpat = d;
                mq.delete();
            end else if (v) begin
                mq.push_back(i);
                if (mq.size() > LEN) void'(mq.pop_front());
                if (mq.size() == LEN) begin
                    val = '0;
                    foreach (mq[k]) val = {val[LEN-2:0], mq[k]};
                    m = (val == mpat);
                end
                if (m && !o) mq.delete();
            end
            if (c) mcnt = m ? 1 : 0;
            else if (m && mcnt < CNT_MAX) mcnt++;
        end
        exp_q.push_back({m, 3'(mcnt)});
    endtask

    task automatic check_sb();
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_out", 32'(out), 32'(e[3]));
`ifdef SEQ_DET_CNT_EN
            chk("sb_cnt", 32'(match_cnt), 32'(e[2:0]));
`endif
        end
    endtask

    // driver: apply one cycle of inputs, advance the model, compare
    task automatic step(input logic r, input logic i, input logic v, input logic o,
                        input logic l, input logic [LEN-1:0] d, input logic c);
        reset = r; in = i; in_valid = v; overlap = o;
        pat_load = l; pat_data = d; cnt_clr = c;
        @(posedge clk);
        model_update(r, i, v, o, l, d, c);
        #1;
        check_sb();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic bit_in(input logic b, input logic o);
        step(1'b0, b, 1'b1, o, 1'b0, '0, 1'b0);
    endtask

    task automatic idle(input logic o);
        step(1'b0, 1'b0, 1'b0, o, 1'b0, '0, 1'b0);
    endtask

    task automatic bits_in(input logic [31:0] bv, input int n, input logic o);
        for (int k = n - 1; k >= 0; k--) bit_in(bv[k], o);
    endtask

    typedef struct {
        logic           rst;
        logic           din;
        logic           vld;
        logic           ovl;
        logic           exp_out;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic d, input logic v,
                                input logic o, input logic eo, input int ec);
        vec_t t;
        t.rst = r; t.din = d; t.vld = v; t.ovl = o;
        t.exp_out = eo; t.exp_cnt = CNT_W'(ec);
        return t;
    endfunction

    initial begin
        reset = 1'b1; in = 1'b0; in_valid = 1'b0; overlap = 1'b0;
        pat_load = 1'b0; pat_data = '0; cnt_clr = 1'b0;
        mpat = RST_PAT; mcnt = 0;

        // basic match, then overlapping and non-overlapping streams
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1));

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n].rst, vecs[n].din, vecs[n].vld, vecs[n].ovl, 1'b0, '0, 1'b0);
            chk($sformatf("vec%0d_out", n), 32'(out), 32'(vecs[n].exp_out));
`ifdef SEQ_DET_CNT_EN
            chk($sformatf("vec%0d_cnt", n), 32'(match_cnt), 32'(vecs[n].exp_cnt));
`endif
            if (vecs[n].rst) chk("reset_state", 32'(dbg_state), 32'd0);
        end

        // gaps are transparent
        do_reset();
        bits_in(32'b110, 3, 1'b0);
        repeat (3) begin
            idle(1'b0);
            chk("gap_out", 32'(out), 32'd0);
        end
        bit_in(1'b1, 1'b0);
        chk("gap_pre", 32'(out), 32'd0);
        bit_in(1'b1, 1'b0);
        chk("gap_match", 32'(out), 32'd1);
        idle(1'b0);
        chk("gap_single", 32'(out), 32'd0);

        // pat_load beats a coincident valid bit
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b10101, 1'b0);
        chk("load_out", 32'(out), 32'd0);
        bits_in(32'b1010, 4, 1'b0);
        chk("load_pre", 32'(out), 32'd0);
        bit_in(1'b1, 1'b0);
        chk("load_match", 32'(out), 32'd1);

        // reset mid-sequence discards progress
        do_reset();
        bits_in(32'b1101, 4, 1'b0);
        do_reset();
        bit_in(1'b1, 1'b0);
        chk("rst_mid", 32'(out), 32'd0);
        bits_in(32'b1011, 4, 1'b0);
        chk("rst_full", 32'(out), 32'd1);

`ifdef SEQ_DET_CNT_EN
        // saturation and coincident clear
        do_reset();
        bits_in(32'b11011, 5, 1'b1);
        repeat (8) bits_in(32'b011, 3, 1'b1);
        chk("cnt_sat", 32'(match_cnt), 32'd7);
        bits_in(32'b01, 2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        chk("cnt_clr_match", 32'(match_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("cnt_clr_only", 32'(match_cnt), 32'd0);
`endif

        // randomized traffic against the model
        do_reset();
        begin
            logic [LEN-1:0] pats [4];
            logic o;
            pats[0] = 5'b11011; pats[1] = 5'b10101; pats[2] = 5'b11111; pats[3] = 5'b00100;
            o = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic r, l, c, v, b;
                if ($urandom_range(0, 49) == 0) o = ~o;
                r = ($urandom_range(0, 299) == 0);
                l = ($urandom_range(0, 59) == 0);
                c = ($urandom_range(0, 39) == 0);
                v = ($urandom_range(0, 3) != 0);
                b = 1'($urandom_range(0, 1));
                step(r, b, v, o, l, pats[$urandom_range(0, 3)], c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
